// File: rtl/i2c_mbyte_seq.sv
// rtl/i2c_mbyte_seq.sv - Wishbone sequencer running multi-byte I2C register transactions on the i2c master core
// Drives TXR/CR writes and SR/RXR reads byte by byte; handles NACK, arbitration loss and TIP timeout.
module i2c_mbyte_seq #(
    parameter int         MAX_BYTES = 4,
    parameter int         LEN_W     = 5,
    parameter int         POLL_MAX  = 65535,
    parameter logic [2:0] ADR_TXR   = 3'd3,
    parameter logic [2:0] ADR_CR    = 3'd4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rd,
    input  logic [6:0]             cmd_dev,
    input  logic [7:0]             cmd_reg,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic [8*MAX_BYTES-1:0] cmd_wdata,
    output logic                   rsp_valid,
    output logic [1:0]             rsp_err,
    output logic [LEN_W-1:0]       rsp_byte,
    output logic [8*MAX_BYTES-1:0] rsp_rdata,
    output logic [2:0]             wb_adr_o,
    output logic [7:0]             wb_dat_o,
    input  logic [7:0]             wb_dat_i,
    output logic                   wb_we_o,
    output logic                   wb_stb_o,
    output logic                   wb_cyc_o,
    input  logic                   wb_ack_i
);

    localparam int DW = 8 * MAX_BYTES;
    localparam int PW = (POLL_MAX > 2) ? $clog2(POLL_MAX) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    localparam logic [7:0] CR_STA_WR  = 8'h90;
    localparam logic [7:0] CR_WR      = 8'h10;
    localparam logic [7:0] CR_STO_WR  = 8'h50;
    localparam logic [7:0] CR_RD_ACK  = 8'h20;
    localparam logic [7:0] CR_STO_RDN = 8'h68;
    localparam logic [7:0] CR_STO     = 8'h40;

    localparam logic [1:0] ERR_NACK = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;
    localparam logic [1:0] ERR_AL   = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_TXR, S_CR, S_POLL, S_CHK, S_RXR, S_STO_CR, S_STO_POLL, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              rd_q, rd_d;
    logic [6:0]        dev_q, dev_d;
    logic [7:0]        reg_q, reg_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [PW-1:0]     poll_q, poll_d;
    logic              sr_al_q, sr_al_d;
    logic              sr_nack_q, sr_nack_d;
    logic [1:0]        err_q, err_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [2:0]        adr_q, adr_d;
    logic [7:0]        dat_q, dat_d;

    logic              acc_req, acc_we, acc_done;
    logic [2:0]        acc_adr;
    logic [7:0]        acc_dat;
    logic [LEN_W-1:0]  base, last_idx, idx_nxt;
    logic              is_data, is_last, rd_byte, nxt_rd_byte;
    logic [7:0]        txr_val, cr_val;

    // Bus byte index: 0 dev addr, 1 reg addr, 2 repeated-start addr on reads, then data.
    assign base        = rd_q ? LEN_W'(3) : LEN_W'(2);
    assign last_idx    = base + len_q - LEN_W'(1);
    assign is_data     = idx_q >= base;
    assign is_last     = idx_q == last_idx;
    assign rd_byte     = rd_q && is_data;
    assign idx_nxt     = idx_q + LEN_W'(1);
    assign nxt_rd_byte = rd_q && (idx_nxt >= base);
    assign acc_done    = stb_q && wb_ack_i;

    always_comb begin
        txr_val = wdata_q[DW-1 -: 8];
        cr_val  = CR_STA_WR;
        if (idx_q == LEN_W'(0)) begin
            txr_val = {dev_q, 1'b0};
        end else if (idx_q == LEN_W'(1)) begin
            txr_val = reg_q;
            cr_val  = CR_WR;
        end else if (!is_data) begin
            txr_val = {dev_q, 1'b1};
        end else if (rd_q) begin
            cr_val  = is_last ? CR_STO_RDN : CR_RD_ACK;
        end else begin
            cr_val  = is_last ? CR_STO_WR : CR_WR;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        len_d     = len_q;
        wdata_d   = wdata_q;
        idx_d     = idx_q;
        poll_d    = poll_q;
        sr_al_d   = sr_al_q;
        sr_nack_d = sr_nack_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        acc_req   = 1'b0;
        acc_we    = 1'b0;
        acc_adr   = ADR_CR;
        acc_dat   = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    rd_d    = cmd_rd;
                    dev_d   = cmd_dev;
                    reg_d   = cmd_reg;
                    len_d   = cmd_len;
                    idx_d   = '0;
                    poll_d  = '0;
                    err_d   = 2'd0;
                    rdata_d = '0;
                    if (cmd_len == '0 || cmd_len > LEN_W'(MAX_BYTES)) begin
                        err_d   = ERR_NACK;
                        wdata_d = '0;
                        state_d = S_DONE;
                    end else begin
                        // Left-align so the first byte to send always sits in the top byte.
                        wdata_d = cmd_wdata << (8 * (MAX_BYTES - int'(cmd_len)));
                        state_d = S_TXR;
                    end
                end
            end
            S_TXR: begin
                acc_req = 1'b1;
                acc_we  = 1'b1;
                acc_adr = ADR_TXR;
                acc_dat = txr_val;
                if (acc_done) begin
                    if (is_data) wdata_d = wdata_q << 8;
                    state_d = S_CR;
                end
            end
            S_CR: begin
                acc_req = 1'b1;
                acc_we  = 1'b1;
                acc_dat = cr_val;
                if (acc_done) begin
                    poll_d  = '0;
                    state_d = S_POLL;
                end
            end
            S_POLL: begin
                acc_req = 1'b1;
                if (acc_done) begin
                    sr_al_d   = wb_dat_i[5];
                    sr_nack_d = wb_dat_i[7];
                    if (!wb_dat_i[1]) begin
                        state_d = S_CHK;
                    end else if (poll_q == POLL_LAST) begin
                        err_d   = ERR_TMO;
                        state_d = S_STO_CR;
                    end else begin
                        poll_d  = poll_q + PW'(1);
                    end
                end
            end
            S_CHK: begin
                if (sr_al_q) begin
                    err_d   = ERR_AL;
                    state_d = S_DONE;
                end else if (!rd_byte && sr_nack_q) begin
                    err_d   = ERR_NACK;
                    state_d = S_STO_CR;
                end else if (rd_byte) begin
                    state_d = S_RXR;
                end else if (is_last) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_nxt;
                    state_d = nxt_rd_byte ? S_CR : S_TXR;
                end
            end
            S_RXR: begin
                acc_req = 1'b1;
                acc_adr = ADR_TXR;
                if (acc_done) begin
                    rdata_d = (rdata_q << 8) | DW'(wb_dat_i);
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_nxt;
                        state_d = S_CR;
                    end
                end
            end
            S_STO_CR: begin
                acc_req = 1'b1;
                acc_we  = 1'b1;
                acc_dat = CR_STO;
                if (acc_done) begin
                    poll_d  = '0;
                    state_d = S_STO_POLL;
                end
            end
            S_STO_POLL: begin
                acc_req = 1'b1;
                if (acc_done) begin
                    if (!wb_dat_i[1] || poll_q == POLL_LAST) state_d = S_DONE;
                    else                                       poll_d  = poll_q + PW'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Single Wishbone transfer: launch from an idle bus, hold until ack, then drop for one cycle.
        stb_d = stb_q;
        we_d  = we_q;
        adr_d = adr_q;
        dat_d = dat_q;
        if (acc_req && !stb_q) begin
            stb_d = 1'b1;
            we_d  = acc_we;
            adr_d = acc_adr;
            dat_d = acc_dat;
        end else if (acc_done) begin
            stb_d = 1'b0;
            we_d  = 1'b0;
            adr_d = 3'd0;
            dat_d = 8'h00;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            rd_q      <= 1'b0;
            dev_q     <= '0;
            reg_q     <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            poll_q    <= '0;
            sr_al_q   <= 1'b0;
            sr_nack_q <= 1'b0;
            err_q     <= 2'd0;
            rdata_q   <= '0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= 3'd0;
            dat_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            len_q     <= len_d;
            wdata_q   <= wdata_d;
            idx_q     <= idx_d;
            poll_q    <= poll_d;
            sr_al_q   <= sr_al_d;
            sr_nack_q <= sr_nack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_err   = err_q;
    assign rsp_byte  = idx_q;
    assign rsp_rdata = rdata_q;
    assign wb_stb_o  = stb_q;
    assign wb_cyc_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;

endmodule

// File: tb/tb_i2c_mbyte_seq.sv
// tb/tb_i2c_mbyte_seq.sv - self-checking bench for i2c_mbyte_seq
// Emulates the i2c core plus one slave at 0x3C behind Wishbone; expectations come from a byte-level model.
module tb_i2c_mbyte_seq;
    localparam int MAXB = 4;
    localparam int LW   = 5;
    localparam int PM   = 8;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i = 1'b1;
    logic            cmd_valid = 1'b0, cmd_rd = 1'b0;
    logic            cmd_ready;
    logic [6:0]      cmd_dev = '0;
    logic [7:0]      cmd_reg = '0;
    logic [LW-1:0]   cmd_len = '0;
    logic [31:0]     cmd_wdata = '0;
    logic            rsp_valid;
    logic [1:0]      rsp_err;
    logic [LW-1:0]   rsp_byte;
    logic [31:0]     rsp_rdata;
    logic [2:0]      wb_adr_o;
    logic [7:0]      wb_dat_o;
    logic [7:0]      wb_dat_i;
    logic            wb_we_o, wb_stb_o, wb_cyc_o;
    logic            wb_ack_i;

    i2c_mbyte_seq #(.MAX_BYTES(MAXB), .LEN_W(LW), .POLL_MAX(PM), .ADR_TXR(3'd3), .ADR_CR(3'd4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_dev(cmd_dev),
        .cmd_reg(cmd_reg), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_byte(rsp_byte), .rsp_rdata(rsp_rdata),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Core + slave environment state
    logic [7:0]  smem [256];
    logic [7:0]  rmem [256];
    logic [7:0]  m_txr, m_rxr, m_ptr;
    bit          m_rxack, m_al, m_idle;
    int          m_busy, m_phase, m_bcnt;
    int          inj_nack = -1, inj_al = -1;
    bit          tip_stuck = 0;
    logic [10:0] wlog [$];
    int          sr_reads, rxr_reads, sr_at_stop, proto_err = 0;
    bit          pend = 0, p_we;
    logic [2:0]  p_adr;
    logic [7:0]  p_dat;
    int          waitc = 0;

    function automatic void model_reset();
        m_busy = 0; m_rxack = 0; m_al = 0; m_idle = 1; m_phase = 0;
        m_txr = 0; m_rxr = 0; m_ptr = 0; m_bcnt = 0;
    endfunction

    function automatic void cr_write(input logic [7:0] d);
        int idx;
        if (d[7]) m_idle = 0;
        if (d[4] || d[5]) begin
            idx = m_bcnt;
            m_bcnt++;
            m_al = (idx == inj_al);
            if (d[4]) begin
                if (d[7]) begin
                    m_rxack = (m_txr[7:1] != 7'h3C) || (idx == inj_nack);
                    m_phase = m_txr[0] ? 2 : 1;
                end else if (m_phase == 1) begin
                    m_rxack = (idx == inj_nack);
                    if (!m_rxack) m_ptr = m_txr;
                    m_phase = 2;
                end else begin
                    m_rxack = (idx == inj_nack);
                    if (!m_rxack) begin smem[m_ptr] = m_txr; m_ptr++; end
                end
            end else begin
                m_rxr = smem[m_ptr];
                m_ptr++;
                m_rxack = d[3];
            end
        end else if (d[6]) begin
            sr_at_stop = sr_reads;
        end
        if (d[6]) m_idle = 1;
        m_busy = tip_stuck ? 1000000 : int'($urandom_range(0, 3));
    endfunction

    function automatic void do_access();
        bit tip;
        if (p_we) begin
            wlog.push_back({p_adr, p_dat});
            if (p_adr == 3'd3)      m_txr = p_dat;
            else if (p_adr == 3'd4) cr_write(p_dat);
        end else if (p_adr == 3'd4) begin
            sr_reads++;
            tip = (m_busy > 0);
            if (tip) m_busy--;
            wb_dat_i = {m_rxack, ~m_idle, m_al, 3'b000, tip, 1'b0};
        end else if (p_adr == 3'd3) begin
            rxr_reads++;
            wb_dat_i = m_rxr;
        end else begin
            wb_dat_i = 8'h00;
        end
    endfunction

    // Wishbone slave with random ack latency; also flags unstable or back-to-back strobes.
    initial begin
        wb_ack_i = 1'b0;
        wb_dat_i = 8'h00;
        forever begin
            @(negedge wb_clk_i);
            if (wb_rst_i) begin
                wb_ack_i = 1'b0; pend = 0; model_reset();
            end else if (wb_ack_i) begin
                wb_ack_i = 1'b0;
                if (wb_stb_o || wb_cyc_o) proto_err++;
            end else if (wb_stb_o) begin
                if (!pend) begin
                    pend = 1; p_adr = wb_adr_o; p_dat = wb_dat_o; p_we = wb_we_o;
                    waitc = $urandom_range(0, 2);
                end else if (p_adr !== wb_adr_o || p_dat !== wb_dat_o || p_we !== wb_we_o || !wb_cyc_o) begin
                    proto_err++;
                end
                if (waitc > 0) waitc--;
                else begin do_access(); wb_ack_i = 1'b1; pend = 0; end
            end
        end
    end

    // Reference: the bus bytes and CR codes a transaction must produce, truncated at the first failure.
    logic [10:0] exp_w [$];
    logic [1:0]  e_err;
    int          e_byte;
    logic [31:0] e_rd;

    function automatic void predict(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                                    input logic [LW-1:0] len, input logic [31:0] wd);
        int L, base, nbus, di;
        bit has_txr, wdir, addr_b, nack;
        logic [7:0] tx, cr;
        exp_w.delete(); e_err = 0; e_byte = 0; e_rd = 0;
        L = int'(len);
        if (L == 0 || L > MAXB) begin e_err = 1; return; end
        base = rd ? 3 : 2;
        nbus = base + L;
        for (int b = 0; b < nbus; b++) begin
            di = b - base;
            has_txr = 1; wdir = 1;
            addr_b = (b == 0) || (rd && b == 2);
            if (b == 0)              begin tx = {dev, 1'b0}; cr = 8'h90; end
            else if (b == 1)         begin tx = rg;          cr = 8'h10; end
            else if (rd && b == 2)   begin tx = {dev, 1'b1}; cr = 8'h90; end
            else if (rd)             begin has_txr = 0; wdir = 0; tx = 0; cr = (di == L-1) ? 8'h68 : 8'h20; end
            else                     begin tx = 8'(wd >> (8*(L-1-di))); cr = (di == L-1) ? 8'h50 : 8'h10; end
            if (has_txr) exp_w.push_back({3'd3, tx});
            exp_w.push_back({3'd4, cr});
            if (b == inj_al) begin e_err = 3; e_byte = b; return; end
            nack = (addr_b && dev != 7'h3C) || (b == inj_nack);
            if (wdir && nack) begin exp_w.push_back({3'd4, 8'h40}); e_err = 1; e_byte = b; return; end
            if (!rd && di >= 0) rmem[8'(int'(rg) + di)] = tx;
            if (rd && di >= 0)  e_rd = (e_rd << 8) | 32'(rmem[8'(int'(rg) + di)]);
        end
    endfunction

    logic [1:0]    r_err;
    logic [LW-1:0] r_byte;
    logic [31:0]   r_rdata;

    task automatic run_cmd(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [LW-1:0] len, input logic [31:0] wd, input bit hold);
        bit got = 0;
        wlog.delete(); sr_reads = 0; rxr_reads = 0; sr_at_stop = -1; m_bcnt = 0;
        @(negedge wb_clk_i);
        cmd_rd = rd; cmd_dev = dev; cmd_reg = rg; cmd_len = len; cmd_wdata = wd; cmd_valid = 1'b1;
        @(negedge wb_clk_i);
        if (hold) begin
            cmd_rd = ~rd; cmd_dev = ~dev; cmd_reg = ~rg; cmd_len = 1; cmd_wdata = ~wd;
        end else begin
            cmd_valid = 1'b0;
        end
        for (int i = 0; i < 4000 && !got; i++) begin
            if (rsp_valid) got = 1;
            else @(negedge wb_clk_i);
        end
        r_err = rsp_err; r_byte = rsp_byte; r_rdata = rsp_rdata;
        cmd_valid = 1'b0;
        if (!got) chk("rsp_within_bound", 0, 1);
        @(negedge wb_clk_i);
        chk("rsp_valid_one_cycle", rsp_valid, 0);
        chk("cmd_ready_after_done", cmd_ready, 1);
    endtask

    task automatic compare_txn(input string tag);
        chk({tag, "_err"}, r_err, e_err);
        if (e_err != 0) chk({tag, "_byte"}, r_byte, e_byte);
        chk({tag, "_rdata"}, r_rdata, e_rd);
        chk({tag, "_nwrites"}, wlog.size(), exp_w.size());
        for (int i = 0; i < wlog.size() && i < exp_w.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), wlog[i], exp_w[i]);
        chk({tag, "_wb_protocol"}, proto_err, 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_rsp_byte"}, rsp_byte, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_wb_ctl"}, {wb_stb_o, wb_cyc_o, wb_we_o}, 0);
        chk({tag, "_wb_adr_dat"}, {wb_adr_o, wb_dat_o}, 0);
    endtask

    task automatic txn(input string tag, input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                       input logic [LW-1:0] len, input logic [31:0] wd, input bit hold);
        predict(rd, dev, rg, len, wd);
        run_cmd(rd, dev, rg, len, wd, hold);
        compare_txn(tag);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v;
        bit rd;
        logic [6:0] dev;
        logic [LW-1:0] len;
        for (int i = 0; i < 256; i++) begin v = 8'($urandom); smem[i] = v; rmem[i] = v; end
        model_reset();
        repeat (3) @(negedge wb_clk_i);
        check_reset("reset");
        wb_rst_i = 1'b0;

        txn("tp_write4", 0, 7'h3C, 8'h04, 5'd4, 32'h12345678, 0);
        chk("tp_write4_mem", {smem[4], smem[5], smem[6], smem[7]}, 32'h12345678);
        txn("tp_read4", 1, 7'h3C, 8'h04, 5'd4, 32'h0, 0);
        chk("tp_read4_const", r_rdata, 32'h12345678);
        chk("tp_read4_rxr_reads", rxr_reads, 4);
        txn("tp_write1", 0, 7'h3C, 8'h01, 5'd1, 32'hA5, 0);
        chk("tp_write1_mem", smem[1], 8'hA5);
        txn("tp_absent", 0, 7'h3D, 8'h00, 5'd2, 32'h1122, 0);
        chk("tp_absent_bus_idle", m_idle, 1);

        // TIP stuck: one address byte, 8 SR polls, STOP, 8 more bounded polls.
        tip_stuck = 1;
        predict(0, 7'h3C, 8'h00, 5'd1, 32'h0);
        exp_w.delete();
        exp_w.push_back({3'd3, 8'h78}); exp_w.push_back({3'd4, 8'h90}); exp_w.push_back({3'd4, 8'h40});
        e_err = 2; e_byte = 0; e_rd = 0;
        run_cmd(0, 7'h3C, 8'h00, 5'd1, 32'h0, 0);
        compare_txn("tp_timeout");
        chk("tp_timeout_sr_before_stop", sr_at_stop, PM);
        chk("tp_timeout_sr_total", sr_reads, 2*PM);
        tip_stuck = 0; m_busy = 0;

        inj_al = 1;
        txn("arb_lost", 0, 7'h3C, 8'h20, 5'd2, 32'hCAFE, 0);
        inj_al = -1;
        repeat (3) @(negedge wb_clk_i);
        chk("rsp_hold_err", rsp_err, 3);
        chk("rsp_hold_byte", rsp_byte, 1);

        txn("len_zero", 0, 7'h3C, 8'h00, 5'd0, 32'h0, 0);
        txn("len_over", 1, 7'h3C, 8'h00, 5'd5, 32'h0, 0);
        txn("busy_ignored", 0, 7'h3C, 8'h10, 5'd2, 32'hBEEF, 1);

        for (int t = 0; t < 24; t++) begin
            rd  = 1'($urandom);
            dev = ($urandom_range(0, 5) == 0) ? 7'h3D : 7'h3C;
            len = LW'($urandom_range(0, 5));
            inj_nack = -1; inj_al = -1;
            if (!rd && $urandom_range(0, 3) == 0) inj_nack = $urandom_range(1, 1 + int'(len));
            if (rd && $urandom_range(0, 5) == 0)  inj_al = $urandom_range(0, 2 + int'(len));
            txn($sformatf("rnd%0d", t), rd, dev, 8'($urandom), len, $urandom, 1'($urandom));
        end
        inj_nack = -1; inj_al = -1;

        // Reset in the middle of a read.
        wlog.delete(); m_bcnt = 0;
        @(negedge wb_clk_i);
        cmd_rd = 1; cmd_dev = 7'h3C; cmd_reg = 8'h04; cmd_len = 5'd4; cmd_valid = 1'b1;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        repeat (20) @(negedge wb_clk_i);
        chk("midread_busy", cmd_ready, 0);
        wb_rst_i = 1'b1;
        model_reset();
        @(negedge wb_clk_i);
        check_reset("midread_rst");
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        proto_err = 0;
        txn("post_reset_read", 1, 7'h3C, 8'h04, 5'd4, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_mbyte_seq.md
Name: i2c_mbyte_seq

Overview:
- Synthesizable Wishbone master that drives the 8-bit i2c master core (PRER/CTR/TXR/RXR/CR/SR map) to run complete multi-byte I2C register transactions from one command.
- Covers write and read (repeated-start) transactions of 1..MAX_BYTES data bytes, MSB byte first.
- Detects NACK, arbitration loss and TIP timeout, and always issues STOP on abort.
- Sits between the PWM register-update logic and the i2c master core. Replaces the hand-sequenced byte-by-byte bus traffic.

Parameters:
MAX_BYTES, 4, maximum data bytes per transaction (1..16)
LEN_W, 5, width of cmd_len (must hold MAX_BYTES)
POLL_MAX, 65535, SR reads allowed per byte before timeout
ADR_TXR, 3, TXR/RXR Wishbone address
ADR_CR, 4, CR/SR Wishbone address

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_rd  in  1  1=read, 0=write
cmd_dev  in  7  7-bit device address
cmd_reg  in  8  slave register address
cmd_len  in  LEN_W  data byte count
cmd_wdata  in  8*MAX_BYTES  write data; first byte sent = bits [8*cmd_len-1 -: 8]
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  2  0 ok, 1 NACK, 2 timeout, 3 arbitration lost
rsp_byte  out  LEN_W  bus byte index of failure (0=device addr)
rsp_rdata  out  8*MAX_BYTES  read data, right-justified, last byte in [7:0]
wb_adr_o  out  3  Wishbone address
wb_dat_o  out  8  Wishbone write data
wb_dat_i  in  8  Wishbone read data
wb_we_o  out  1  write enable
wb_stb_o  out  1  strobe
wb_cyc_o  out  1  cycle
wb_ack_i  in  1  acknowledge

Behaviour:
- Reset: state IDLE; cmd_ready=1; rsp_valid=0, rsp_err=0, rsp_byte=0, rsp_rdata=0; wb_stb_o=wb_cyc_o=wb_we_o=0; wb_adr_o=0, wb_dat_o=0.
- Reset mid-transaction aborts immediately with no STOP issued. The core is reset from the same wb_rst_i.
- Command accept: cmd_valid && cmd_ready latches all cmd_* fields.
  - cmd_len==0 or cmd_len>MAX_BYTES: no bus traffic; rsp_valid next cycle with rsp_err=1, rsp_byte=0.
  - cmd_valid while busy is ignored, not queued.
- Wishbone access: single transfers only.
  - stb/cyc/we/adr/dat are held stable until wb_ack_i.
  - Outputs drop the cycle after ack and stay low at least one cycle before the next access.
  - No ack means the sequencer waits indefinitely; POLL_MAX applies only to SR polling.
- Byte step, states TXR -> CR -> POLL -> CHK:
  - TXR: write TXR (skipped for read-data bytes).
  - CR: write CR.
  - POLL: read SR repeatedly until SR[1] (TIP) = 0.
  - POLL_MAX reads with TIP still 1 -> err 2.
  - CHK: SR[5] (AL) = 1 -> err 3, terminate with no STOP.
  - CHK: on write-direction bytes, SR[7] (RxACK) = 1 -> err 1.
- Write sequence:
  - TXR={dev,0}, CR=0x90
  - TXR=reg, CR=0x10
  - each data byte CR=0x10; last data byte CR=0x50 (STO|WR)
- Read sequence:
  - TXR={dev,0}, CR=0x90
  - TXR=reg, CR=0x10 (no stop)
  - TXR={dev,1}, CR=0x90 (repeated start)
  - non-last data bytes CR=0x20 (RD, ACK); last CR=0x68 (STO|RD|NACK)
  - after each data byte's POLL, read RXR and shift it into rsp_rdata; upper unused bytes are 0.
- Abort on err 1 or 2: write CR=0x40 (STO), poll until TIP=0 (bounded by POLL_MAX), then DONE.
- rsp_byte counts bus bytes sent: 0=dev addr, 1=reg addr, 2=repeated-start addr (read only), then data bytes.
- DONE: rsp_valid=1 for exactly one cycle. rsp_err, rsp_byte and rsp_rdata hold until the next accept. Next cycle IDLE, cmd_ready=1.
- Prescaler and CTR (core enable) are not touched; software configures them before use.

Test Plan:
- Write dev=0x3C reg=0x04 len=4 wdata=0x12345678 with an ack-ing slave.
  - Required Wishbone write sequence: (3,0x78)(4,0x90)(3,0x04)(4,0x10)(3,0x12)(4,0x10)(3,0x34)(4,0x10)(3,0x56)(4,0x10)(3,0x78)(4,0x50).
  - rsp_err=0; slave register 0x04 = 0x12345678.
- Read dev=0x3C reg=0x04 len=4 after the write above.
  - CR writes 0x90,0x10,0x90,0x20,0x20,0x20,0x68; four RXR reads.
  - rsp_rdata=0x12345678, err=0.
- Write len=1 dev=0x3C reg=0x01 wdata=0xA5 -> CR writes 0x90,0x10,0x50; rsp_rdata=0; err=0; slave reg 0x01=0xA5.
- Write to absent dev=0x3D -> RxACK=1 after the address byte.
  - Abort writes CR=0x40; rsp_err=1, rsp_byte=0.
  - Bus ends with STOP, SDA/SCL idle high.
- Wishbone model holds TIP=1 with POLL_MAX=8 -> exactly 8 SR reads, then CR=0x40; rsp_err=2.
- Edge cases:
  - cmd_len=0 -> no Wishbone cycles, rsp_err=1.
  - cmd_valid during a busy transaction is ignored.
  - wb_rst_i asserted mid-read -> next cycle all outputs at reset values, cmd_ready=1.
